// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, the engine FSM encoding and the
// forward/inverse S-box tables used by every substitution lane.
package aes_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_BYTES   = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_state_e;

   // Forward S-box, entry 0x00 in the top byte, entry 0xff in the bottom byte.
   localparam logic [2047:0] SBOX_FWD_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Inverse S-box, same layout as the forward table.
   localparam logic [2047:0] SBOX_INV_TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   // Entry b sits at bit offset (255-b)*8, and 255-b is simply ~b.
   function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
      return SBOX_FWD_TBL[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] b);
      return SBOX_INV_TBL[{~b, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/sbox_dual.sv
// One combinational substitution lane: forward or inverse AES S-box.
module sbox_dual
   import aes_pkg::*;
(
   input  logic [7:0] din,
   input  logic       inv,
   output logic [7:0] dout
);

   // Table lookup selected by direction; no state in the lane.
   always_comb begin
      dout = inv ? sbox_inv(din) : sbox_fwd(din);
   end

endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-cycle SubBytes / InvSubBytes over a 128-bit state, LANES bytes per
// cycle. Byte 0 is state[127:120], byte 15 is state[7:0].
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the source holds valid and data stable until that edge, and
// ready never depends combinationally on valid.
module sub_bytes_engine
   import aes_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] in_state,
   input  logic                   in_inv,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_STATE_W-1:0] out_state,
   output logic                   busy,
   output fsm_state_e             dbg_state
);

   localparam int BEATS  = AES_BYTES / LANES;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   // Only power-of-two lane counts up to a full state tile the 16 bytes.
   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
   end

   fsm_state_e             state;
   logic [AES_STATE_W-1:0] work;
   logic [AES_STATE_W-1:0] work_next;
   logic [BEAT_W-1:0]      beat;
   logic                   inv_q;

   logic [3:0]             byte_idx [LANES];
   logic [7:0]             lane_in  [LANES];
   logic [7:0]             lane_out [LANES];

   // Each lane picks the byte for the current beat and runs it through an S-box.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign byte_idx[i] = 4'(int'(beat) * LANES + i);
      assign lane_in[i]  = work[{~byte_idx[i], 3'b000} +: 8];

      sbox_dual u_sbox (
         .din  (lane_in[i]),
         .inv  (inv_q),
         .dout (lane_out[i])
      );
   end

   // Merge the substituted bytes back into their slots; other bytes pass through.
   always_comb begin
      work_next = work;
      for (int i = 0; i < LANES; i++) begin
         work_next[{~byte_idx[i], 3'b000} +: 8] = lane_out[i];
      end
   end

   // Control FSM plus working register, beat counter and direction flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         work  <= '0;
         beat  <= '0;
         inv_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  work  <= in_state;
                  inv_q <= in_inv;
                  beat  <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               work <= work_next;
               if (beat == BEAT_W'(BEATS - 1)) begin
                  beat  <= '0;
                  state <= DONE;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Ready is held low while reset is asserted so nothing is accepted then.
   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_state = work;
   assign dbg_state = state;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: three instances (LANES = 4, 1, 16)
// with FIPS-197 vectors, single-byte cases, backpressure, mid-block reset and
// handshake discipline.
module tb_sub_bytes_engine;
  import aes_pkg::*;

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] SB_F_IN  = 128'h52e99f00_52e99f00_52e99f00_52e99f00;
  localparam logic [127:0] SB_F_OUT = 128'h001edb63_001edb63_001edb63_001edb63;
  localparam logic [127:0] SB_I_IN  = 128'h0063_0063_0063_0063_0063_0063_0063_0063;
  localparam logic [127:0] SB_I_OUT = 128'h5200_5200_5200_5200_5200_5200_5200_5200;
  localparam logic [127:0] ALL_63   = {16{8'h63}};

  logic clk;
  logic         rst_v       [3];
  logic         in_valid_v  [3];
  logic         in_ready_v  [3];
  logic [127:0] in_state_v  [3];
  logic         in_inv_v    [3];
  logic         out_valid_v [3];
  logic         out_ready_v [3];
  logic [127:0] out_state_v [3];
  logic         busy_v      [3];
  fsm_state_e   dbg_v       [3];

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sub_bytes_engine #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_state(in_state_v[0]), .in_inv(in_inv_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .out_state(out_state_v[0]), .busy(busy_v[0]),
    .dbg_state(dbg_v[0])
  );

  sub_bytes_engine #(.LANES(1)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_state(in_state_v[1]), .in_inv(in_inv_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .out_state(out_state_v[1]), .busy(busy_v[1]),
    .dbg_state(dbg_v[1])
  );

  sub_bytes_engine #(.LANES(16)) u_dut16 (
    .clk(clk), .rst(rst_v[2]), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_state(in_state_v[2]), .in_inv(in_inv_v[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .out_state(out_state_v[2]), .busy(busy_v[2]),
    .dbg_state(dbg_v[2])
  );

  // ---------------- checkers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [127:0] st, input logic inv);
    int n;
    n = 0;
    in_valid_v[d] = 1'b1;
    in_state_v[d] = st;
    in_inv_v[d]   = inv;
    #1;
    while (!in_ready_v[d] && n < 20) begin
      tick();
      n++;
    end
    chk1("send_ready", in_ready_v[d], 1'b1);
    tick();
    in_valid_v[d] = 1'b0;
    in_state_v[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_inv_v[d]   = ~inv;
    chk1("busy_after_accept", busy_v[d], 1'b1);
  endtask

  task automatic wait_done(input int d, input string tag, input int exp_lat,
                           input logic [127:0] exp_state);
    int n;
    n = 0;
    while (!out_valid_v[d] && n < 40) begin
      tick();
      n++;
    end
    chk_int({tag, "_latency"}, n, exp_lat);
    chk({tag, "_state"}, out_state_v[d], exp_state);
  endtask

  task automatic take(input int d, input string tag);
    out_ready_v[d] = 1'b1;
    tick();
    out_ready_v[d] = 1'b0;
    chk1({tag, "_out_valid_drop"}, out_valid_v[d], 1'b0);
    chk1({tag, "_in_ready_back"}, in_ready_v[d], 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_v[d]       = 1'b1;
      in_valid_v[d]  = 1'b0;
      in_state_v[d]  = '0;
      in_inv_v[d]    = 1'b0;
      out_ready_v[d] = 1'b0;
    end

    // reset state
    tick();
    tick();
    for (int d = 0; d < 3; d++) chk1("in_ready_during_reset", in_ready_v[d], 1'b0);
    for (int d = 0; d < 3; d++) rst_v[d] = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk1("reset_out_valid", out_valid_v[d], 1'b0);
      chk("reset_out_state", out_state_v[d], 128'h0);
      chk1("reset_busy", busy_v[d], 1'b0);
      chk1("reset_in_ready", in_ready_v[d], 1'b1);
    end
    chk_int("reset_dbg_state", int'(dbg_v[0]), int'(IDLE));

    // FIPS-197 forward vector on every lane count
    send(0, FIPS_IN, 1'b0);
    wait_done(0, "fips_fwd_l4", 4, FIPS_OUT);
    take(0, "fips_fwd_l4");
    send(1, FIPS_IN, 1'b0);
    wait_done(1, "fips_fwd_l1", 16, FIPS_OUT);
    take(1, "fips_fwd_l1");
    send(2, FIPS_IN, 1'b0);
    wait_done(2, "fips_fwd_l16", 1, FIPS_OUT);
    take(2, "fips_fwd_l16");

    // FIPS-197 inverse vector
    send(0, FIPS_OUT, 1'b1);
    wait_done(0, "fips_inv_l4", 4, FIPS_IN);
    take(0, "fips_inv_l4");
    send(2, FIPS_OUT, 1'b1);
    wait_done(2, "fips_inv_l16", 1, FIPS_IN);
    take(2, "fips_inv_l16");

    // single-byte cases: 52->00 e9->1e 9f->db 00->63, inverse 00->52 63->00
    send(0, SB_F_IN, 1'b0);
    wait_done(0, "single_fwd", 4, SB_F_OUT);
    take(0, "single_fwd");
    send(1, SB_I_IN, 1'b1);
    wait_done(1, "single_inv", 16, SB_I_OUT);
    take(1, "single_inv");

    // backpressure in DONE, with in_valid toggling on new data meanwhile
    send(0, FIPS_IN, 1'b0);
    wait_done(0, "bp", 4, FIPS_OUT);
    for (int k = 0; k < 10; k++) begin
      in_valid_v[0] = k[0];
      in_state_v[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      chk1("bp_out_valid_hold", out_valid_v[0], 1'b1);
      chk("bp_out_state_hold", out_state_v[0], FIPS_OUT);
      chk1("bp_in_ready_low", in_ready_v[0], 1'b0);
    end
    in_valid_v[0] = 1'b0;
    take(0, "bp");
    chk("bp_out_state_kept", out_state_v[0], FIPS_OUT);
    tick();
    chk1("bp_no_stray_accept", busy_v[0], 1'b0);

    // reset at beat 2, then a fresh all-zero block
    send(0, FIPS_IN, 1'b0);
    tick();
    tick();
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    #1;
    chk1("midrst_out_valid", out_valid_v[0], 1'b0);
    chk("midrst_out_state", out_state_v[0], 128'h0);
    chk1("midrst_busy", busy_v[0], 1'b0);
    chk1("midrst_in_ready", in_ready_v[0], 1'b1);
    send(0, 128'h0, 1'b0);
    wait_done(0, "midrst_zero_block", 4, ALL_63);
    take(0, "midrst_zero_block");

    // in_valid toggling while busy must not cause a second accept
    send(0, FIPS_OUT, 1'b1);
    for (int k = 0; k < 3; k++) begin
      in_valid_v[0] = ~in_valid_v[0];
      in_state_v[0] = 128'h0;
      in_inv_v[0]   = 1'b0;
      tick();
    end
    in_valid_v[0] = 1'b0;
    wait_done(0, "toggle_busy", 1, FIPS_IN);
    take(0, "toggle_busy");
    tick();
    chk1("toggle_busy_idle", busy_v[0], 1'b0);

    // back-to-back blocks with opposite directions
    send(0, 128'h0, 1'b0);
    wait_done(0, "b2b_first_fwd", 4, ALL_63);
    in_valid_v[0] = 1'b1;
    in_state_v[0] = FIPS_OUT;
    in_inv_v[0]   = 1'b1;
    take(0, "b2b_first_fwd");
    send(0, FIPS_OUT, 1'b1);
    wait_done(0, "b2b_second_inv", 4, FIPS_IN);
    take(0, "b2b_second_inv");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
